instr_fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the 32-bit instruction word whose opcode field drives the opcode decoder/control unit.
- Holds the PC and runs a one-outstanding request/ready handshake with instruction memory.
- Buffers one fetched instruction toward decode with valid/ready stall, and accepts branch/jump redirects from execute with flush and discard of in-flight responses.

---
 rtl/instr_fetch_unit_pkg.sv | 42 ++++
 rtl/instr_fetch_unit_pc_reg.sv | 33 +++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: opcodes, NOP word,
// fetch-state encoding and instruction field positions.
package instr_fetch_unit_pkg;

    // Primary opcodes seen by the control unit
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Word presented to decode when nothing has been fetched yet
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Instruction size in bytes; also defines the word-alignment mask
    localparam int INSTR_BYTES = 4;

    // Instruction field slice positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // FETCH: request outstanding or about to be issued
    // HOLD:  one instruction buffered toward decode, memory idle
    // DROP:  waiting out a request made stale by a redirect
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetchState_e;

    function automatic logic [5:0] opField(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] functField(input logic [31:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: reset value, sequential +4 advance and redirect load.
// A redirect wins over the increment; the low address bits of a redirect
// target are cleared so the PC always stays word aligned.
module instr_fetch_unit_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              incEn,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] alignedLoad;

    assign alignedLoad = loadAddr & ~ADDR_W'(INSTR_BYTES - 1);

    // PC update: redirect load has priority, otherwise advance one word (wraps)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (loadEn) begin
            pc <= alignedLoad;
        end else if (incEn) begin
            pc <= pc + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end. Keeps one request in flight to instruction
// memory, buffers a single fetched instruction toward decode, and handles
// redirects from execute by flushing the buffer and discarding any response
// that belongs to the old instruction stream.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [31:0]       if_instr,
    output logic [5:0]        if_op,
    output logic [5:0]        if_funct,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target
);

    fetchState_e       state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] dropAddr;
    logic              reqReg;
    logic              validReg;
    logic [31:0]       instrReg;
    logic [ADDR_W-1:0] instrPcReg;
    logic              pcInc;

    // The PC only advances when a live response is captured into the buffer
    assign pcInc = (state == FETCH) && reqReg && imem_rdy && !br_taken;

    instr_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk      (clk),
        .rst      (rst),
        .incEn    (pcInc),
        .loadEn   (br_taken),
        .loadAddr (br_target),
        .pc       (pc)
    );

    // Fetch FSM with the decode-side buffer; the request line is registered
    // so it is low straight out of reset and rises on the first clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            reqReg     <= 1'b0;
            dropAddr   <= RESET_PC;
            validReg   <= 1'b0;
            instrReg   <= NOP_WORD;
            instrPcReg <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (!reqReg) begin
                        reqReg <= 1'b1;
                    end else if (br_taken) begin
                        validReg <= 1'b0;
                        if (!imem_rdy) begin
                            dropAddr <= pc;
                            state    <= DROP;
                        end
                    end else if (imem_rdy) begin
                        instrReg   <= imem_rdata;
                        instrPcReg <= pc;
                        validReg   <= 1'b1;
                        reqReg     <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (br_taken || id_ready) begin
                        validReg <= 1'b0;
                        reqReg   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DROP: begin
                    validReg <= 1'b0;
                    if (imem_rdy) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    validReg <= 1'b0;
                    reqReg   <= 1'b1;
                    state    <= FETCH;
                end
            endcase
        end
    end

    assign imem_req  = reqReg;
    assign imem_addr = (state == DROP) ? dropAddr : pc;
    assign if_valid  = validReg;
    assign if_instr  = instrReg;
    assign if_op     = opField(instrReg);
    assign if_funct  = functField(instrReg);
    assign if_pc     = instrPcReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations followed by a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] if_instr;
    logic [5:0]  if_op;
    logic [5:0]  if_funct;
    logic [31:0] if_pc;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;

    int compareCount  = 0;
    int mismatchCount = 0;

    int curLatency    = 0;
    bit randomLatency = 1'b0;
    int memCnt        = 0;

    // Model state: buffered instruction, next fetch address and whether an
    // outstanding request belongs to a flushed stream
    logic [31:0] mPc, mHoldAddr, mInstr, mIfPc;
    bit          mValid, mReq, mDiscard;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .id_ready   (id_ready),
        .if_instr   (if_instr),
        .if_op      (if_op),
        .if_funct   (if_funct),
        .if_pc      (if_pc),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C22_0004;
            32'h0000_0010: return 32'h2002_000A;
            default:       return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic br, input logic [31:0] target, input logic idReady);
        br_taken  = br;
        br_target = target;
        id_ready  = idReady;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitReq(input int maxCycles);
        for (int n = 0; n < maxCycles && !imem_req; n++) tick();
        checkOutput("waitReq", imem_req, 1);
    endtask

    task automatic waitValid(input int maxCycles);
        for (int n = 0; n < maxCycles && !if_valid; n++) tick();
        checkOutput("waitValid", if_valid, 1);
    endtask

    // Instruction memory: answers each request after curLatency extra cycles
    always @(negedge clk) begin
        if (rst || !imem_req) begin
            memCnt   = 0;
            imem_rdy = 1'b0;
        end else begin
            if (memCnt == 0 && randomLatency) curLatency = $urandom_range(0, 3);
            if (memCnt >= curLatency) begin
                imem_rdy   = 1'b1;
                imem_rdata = memWord(imem_addr);
                memCnt     = 0;
            end else begin
                imem_rdy   = 1'b0;
                imem_rdata = $urandom;
                memCnt++;
            end
        end
    end

    task automatic resetModel();
        mPc = 32'h0; mHoldAddr = 32'h0; mInstr = 32'h0; mIfPc = 32'h0;
        mValid = 1'b0; mReq = 1'b0; mDiscard = 1'b0;
    endtask

    task automatic updateModel();
        bit completed;
        completed = mReq && imem_rdy;
        if (br_taken) begin
            if (mReq && !imem_rdy && !mDiscard) begin
                mDiscard  = 1'b1;
                mHoldAddr = mPc;
            end else if (completed && mDiscard) begin
                mDiscard = 1'b0;
            end
            mPc    = br_target & ~32'h3;
            mValid = 1'b0;
        end else if (completed) begin
            if (mDiscard) begin
                mDiscard = 1'b0;
            end else begin
                mInstr = imem_rdata;
                mIfPc  = mPc;
                mValid = 1'b1;
                mPc    = mPc + 32'd4;
            end
        end else if (mValid && id_ready) begin
            mValid = 1'b0;
        end
        mReq = mDiscard || !mValid;
    endtask

    // Advance the model on every edge and compare all outputs just after it
    always @(posedge clk) begin
        if (rst) resetModel();
        else updateModel();
        #1;
        checkOutput("req",   imem_req,  mReq);
        checkOutput("addr",  imem_addr, mDiscard ? mHoldAddr : mPc);
        checkOutput("valid", if_valid,  mValid);
        checkOutput("instr", if_instr,  mInstr);
        checkOutput("op",    if_op,     mInstr[31:26]);
        checkOutput("funct", if_funct,  mInstr[5:0]);
        checkOutput("ifPc",  if_pc,     mIfPc);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] target;
        $display("[TB] starting instr_fetch_unit bench");

        // Reset values
        applyStimulus(0, 32'h0, 1);
        tick();
        checkOutput("rstReq",   imem_req,  0);
        checkOutput("rstAddr",  imem_addr, 32'h0);
        checkOutput("rstValid", if_valid,  0);
        checkOutput("rstInstr", if_instr,  32'h0);
        checkOutput("rstPc",    if_pc,     32'h0);

        // Zero-wait sequential fetch with decode always ready
        curLatency = 0;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            waitReq(20);
            checkOutput("seqAddr", imem_addr, 32'(i * 4));
            tick();
            checkOutput("seqValid", if_valid, 1);
            checkOutput("seqPc", if_pc, 32'(i * 4));
            if (i == 0) begin
                checkOutput("lwInstr", if_instr, 32'h8C22_0004);
                checkOutput("lwOp", if_op, 6'b100011);
                checkOutput("lwFunct", if_funct, 6'b000100);
            end
        end

        // Decode stall holds the buffer and keeps memory idle
        applyStimulus(0, 32'h0, 0);
        applyReset();
        applyStimulus(1, 32'h10, 0);
        tick();
        applyStimulus(0, 32'h0, 0);
        waitValid(20);
        checkOutput("stallInstr", if_instr, 32'h2002_000A);
        checkOutput("stallPc", if_pc, 32'h10);
        checkOutput("stallOp", if_op, 6'b001000);
        checkOutput("stallFunct", if_funct, 6'b001010);
        repeat (5) begin
            tick();
            checkOutput("holdInstr", if_instr, 32'h2002_000A);
            checkOutput("holdPc", if_pc, 32'h10);
            checkOutput("holdReq", imem_req, 0);
            checkOutput("holdValid", if_valid, 1);
        end
        applyStimulus(0, 32'h0, 1);
        tick();
        checkOutput("releaseValid", if_valid, 0);
        checkOutput("releaseReq", imem_req, 1);
        checkOutput("releaseAddr", imem_addr, 32'h14);

        // Redirect while a slow request is in flight
        curLatency = 3;
        applyStimulus(0, 32'h0, 1);
        applyReset();
        waitReq(20);
        tick();
        applyStimulus(1, 32'h40, 1);
        tick();
        applyStimulus(0, 32'h0, 1);
        for (int n = 0; n < 10; n++) begin
            checkOutput("dropAddr", imem_addr, 32'h0);
            checkOutput("dropReq", imem_req, 1);
            checkOutput("dropValid", if_valid, 0);
            if (imem_rdy) break;
            tick();
        end
        checkOutput("dropRdy", imem_rdy, 1);
        tick();
        checkOutput("redirReq", imem_req, 1);
        checkOutput("redirAddr", imem_addr, 32'h40);
        checkOutput("redirValid", if_valid, 0);
        waitValid(20);
        checkOutput("redirPc", if_pc, 32'h40);

        // Redirect in HOLD beats a simultaneous decode accept
        curLatency = 0;
        applyStimulus(0, 32'h0, 0);
        applyReset();
        waitValid(20);
        checkOutput("holdBrPcBefore", if_pc, 32'h0);
        applyStimulus(1, 32'h103, 1);
        tick();
        applyStimulus(0, 32'h0, 0);
        checkOutput("holdBrValid", if_valid, 0);
        checkOutput("holdBrReq", imem_req, 1);
        checkOutput("holdBrAddr", imem_addr, 32'h100);
        waitValid(20);
        checkOutput("holdBrPc", if_pc, 32'h100);

        // PC wraps from the top word back to zero
        applyStimulus(0, 32'h0, 1);
        applyReset();
        applyStimulus(1, 32'hFFFF_FFFF, 1);
        tick();
        applyStimulus(0, 32'h0, 1);
        waitValid(20);
        checkOutput("wrapPc", if_pc, 32'hFFFF_FFFC);
        waitReq(20);
        checkOutput("wrapAddr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a slow request
        curLatency = 4;
        applyStimulus(0, 32'h0, 1);
        applyReset();
        waitValid(30);
        checkOutput("preRstInstr", if_instr, 32'h8C22_0004);
        waitReq(30);
        checkOutput("preRstAddr", imem_addr, 32'h4);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstReq", imem_req, 0);
        checkOutput("midRstValid", if_valid, 0);
        checkOutput("midRstInstr", if_instr, 32'h0);
        checkOutput("midRstAddr", imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        checkOutput("postRstReq0", imem_req, 0);
        tick();
        checkOutput("postRstReq1", imem_req, 1);
        checkOutput("postRstAddr", imem_addr, 32'h0);

        // Randomized traffic against the model
        randomLatency = 1'b1;
        applyStimulus(0, 32'h0, 1);
        applyReset();
        for (int c = 0; c < 3000; c++) begin
            target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus($urandom_range(0, 7) == 0, target, $urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(0, 32'h0, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
